fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 13 +
 rtl/fetch_ctrl_if.sv | 22 ++
 rtl/fetch_ctrl_skid.sv | 23 ++
 rtl/fetch_ctrl.sv | 92 +++++++++
 tb/tb_fetch_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: reset PC, PC increment, FSM encoding and skid payload shared by the fetch block
package fetch_ctrl_pkg;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } skid_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: hazard/redirect inputs, instruction-memory port and IF/ID outputs of fetch_ctrl
interface fetch_ctrl_if;
  logic stall;
  logic redirect;
  logic [31:0] redirect_pc;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ack;
  logic [31:0] imem_rdata;
  logic if_valid;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic [31:0] pc4_if;
  modport master (
    input stall, redirect, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_valid, instr_if, pc_if, pc4_if
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_ack, imem_rdata,
    input imem_req, imem_addr, if_valid, instr_if, pc_if, pc4_if
  );
endinterface

// File: rtl/fetch_ctrl_skid.sv
// fetch_skid: one-entry buffer holding a fetched word and its PC while IF/ID is stalled
module fetch_skid
  import fetch_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  unload,
  input  logic  clear,
  input  skid_t din,
  output skid_t dout,
  output logic  valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout <= '0;
    end else begin
      valid <= !(clear || unload) && (load || valid);
      if (load && !clear) dout <= din;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch controller with skid and redirect drop; DELAY_SLOT_EN keeps IF/ID on redirect
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input logic clk,
  input logic rst_n,
  fetch_ctrl_if.master bus
);
  state_t state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n, drop_pc, drop_pc_n, instr, instr_n, pc, pc_n;
  logic drop, drop_n, valid, valid_n;
  logic fetching, hit, skid_load, skid_unload, skid_valid;
  skid_t skid_out;
  assign fetching = state == FETCH;
  assign hit = fetching && bus.imem_ack && !drop && !bus.redirect;
  assign skid_load = hit && bus.stall;
  assign skid_unload = state == HOLD && !bus.stall && !bus.redirect;
  // while dropping, the abandoned address stays on the bus until its ack returns
  assign bus.imem_req = fetching;
  assign bus.imem_addr = drop ? drop_pc : fetch_pc;
  assign bus.if_valid = valid;
  assign bus.instr_if = instr;
  assign bus.pc_if = pc;
  assign bus.pc4_if = pc + PC_INC;
  fetch_skid u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .load(skid_load),
    .unload(skid_unload),
    .clear(bus.redirect),
    .din({bus.imem_rdata, fetch_pc}),
    .dout(skid_out),
    .valid(skid_valid)
  );
  always_comb begin
    state_n = state;
    fetch_pc_n = fetch_pc;
    drop_n = drop;
    drop_pc_n = drop_pc;
    valid_n = valid;
    instr_n = instr;
    pc_n = pc;
    if (bus.redirect) begin
      state_n = FETCH;
      fetch_pc_n = word_align(bus.redirect_pc);
      drop_n = fetching && !bus.imem_ack;
      drop_pc_n = bus.imem_addr;
`ifndef DELAY_SLOT_EN
      valid_n = 1'b0;
`endif
    end else if (state == IDLE) begin
      state_n = FETCH;
    end else if (state == HOLD) begin
      if (!bus.stall) begin
        state_n = FETCH;
        valid_n = skid_valid;
        instr_n = skid_out.instr;
        pc_n = skid_out.pc;
      end
    end else begin
      if (!bus.stall) valid_n = hit;
      if (hit && !bus.stall) begin
        instr_n = bus.imem_rdata;
        pc_n = fetch_pc;
      end
      if (hit) begin
        fetch_pc_n = fetch_pc + PC_INC;
        state_n = bus.stall ? HOLD : FETCH;
      end
      if (bus.imem_ack) drop_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      drop <= 1'b0;
      drop_pc <= RESET_PC;
      valid <= 1'b0;
      instr <= '0;
      pc <= RESET_PC;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      drop <= drop_n;
      drop_pc <= drop_pc_n;
      valid <= valid_n;
      instr <= instr_n;
      pc <= pc_n;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized stimulus for fetch_ctrl checked against a fetch-stream model
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fetch_ctrl_if bus ();
  fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  int n_chk = 0;
  int n_pass = 0;
  int lat_base = 0;
  int lat_rand = 0;
  int wcnt = 0;
  bit mem_rand = 1'b0;
  bit ack_force = 1'b0;
  assign bus.imem_ack = ack_force || (bus.imem_req && wcnt >= (mem_rand ? lat_rand : lat_base));
  assign bus.imem_rdata = {bus.imem_addr[15:0] ^ 16'hC0DE, bus.imem_addr[31:16]};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else begin
      wcnt <= 0;
      if (bus.imem_ack) lat_rand <= $urandom_range(0, 3);
    end
  end
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;
  entry_t held[$];
  bit m_run, m_disc, m_v;
  logic [31:0] m_pc, m_disc_pc, m_i, m_p;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  task automatic model_reset();
    m_run = 1'b0;
    m_disc = 1'b0;
    m_v = 1'b0;
    m_pc = 32'h0000_3000;
    m_disc_pc = 32'h0000_3000;
    m_i = '0;
    m_p = 32'h0000_3000;
    held.delete();
  endtask
  task automatic check_reset(input string tag);
    chk({tag, ".imem_req"}, bus.imem_req, 0);
    chk({tag, ".if_valid"}, bus.if_valid, 0);
    chk({tag, ".instr_if"}, bus.instr_if, 0);
    chk({tag, ".pc_if"}, bus.pc_if, 32'h0000_3000);
    chk({tag, ".pc4_if"}, bus.pc4_if, 32'h0000_3004);
  endtask
  task automatic check_model();
    bit exp_req;
    exp_req = m_run && held.size() == 0;
    chk("imem_req", bus.imem_req, exp_req);
    if (exp_req) chk("imem_addr", bus.imem_addr, m_disc ? m_disc_pc : m_pc);
    chk("if_valid", bus.if_valid, m_v);
    if (m_v) begin
      chk("instr_if", bus.instr_if, m_i);
      chk("pc_if", bus.pc_if, m_p);
      chk("pc4_if", bus.pc4_if, m_p + 32'd4);
    end
  endtask
  // one clock of the fetch stream: what is requested, delivered, parked or thrown away
  task automatic step();
    bit a, s, req;
    a = bus.imem_ack;
    s = bus.stall;
    req = m_run && held.size() == 0;
    if (bus.redirect) begin
      if (req && !a) begin
        if (!m_disc) m_disc_pc = m_pc;
        m_disc = 1'b1;
      end else m_disc = 1'b0;
      m_pc = bus.redirect_pc & ~32'h3;
      held.delete();
      m_run = 1'b1;
`ifndef DELAY_SLOT_EN
      m_v = 1'b0;
`endif
    end else if (!m_run) m_run = 1'b1;
    else if (held.size() != 0) begin
      if (!s) begin
        m_v = 1'b1;
        m_i = held[0].instr;
        m_p = held[0].pc;
        held.delete();
      end
    end else begin
      if (!s) m_v = 1'b0;
      if (a && m_disc) m_disc = 1'b0;
      else if (a) begin
        if (s) held.push_back('{instr: bus.imem_rdata, pc: m_pc});
        else begin
          m_v = 1'b1;
          m_i = bus.imem_rdata;
          m_p = m_pc;
        end
        m_pc += 32'd4;
      end
    end
  endtask
  task automatic cycle(input bit s, input bit r, input logic [31:0] rpc);
    check_model();
    bus.stall = s;
    bus.redirect = r;
    bus.redirect_pc = rpc;
    #1 step();
    @(negedge clk);
  endtask
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    ack_force = 1'b1;
    #1 check_reset("async_rst");
    @(negedge clk);
    check_reset("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    ack_force = 1'b0;
    model_reset();
  endtask
  function automatic logic [31:0] rand_pc();
    return $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
  endfunction
  initial begin
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    lat_base = 3;
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_3100);
    repeat (10) cycle(1'b0, 1'b0, 32'h0);
    lat_base = 0;
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_3200);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_4002);
    cycle(1'b1, 1'b0, 32'h0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    lat_base = 3;
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    mid_reset();
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
    mem_rand = 1'b1;
    repeat (600) cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, rand_pc());
    mid_reset();
    repeat (200) cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, rand_pc());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
